// File: rtl/ycc_stream_scheduler_if.sv
// rtl/ycc_stream_scheduler_if.sv - Bundle of Y/Cb/Cr input strobes and the ordered output stream
//
// Purpose: groups every non-clock/reset signal of ycc_stream_scheduler.
// Signals:
//   y_/cb_/cr_bitstream[31:0], *_data_ready, *_orc[4:0], *_eob : per-component encoder words
//   out_bitstream[31:0], out_orc[4:0], out_eob, out_channel[1:0], out_valid : served head word
//   out_ready : downstream accept
//   mcu_count[15:0], ovf_flags[2:0] {cr,cb,y}, stall_err : status
// Modports:
//   master : the encoder/packer side (drives component words and out_ready)
//   slave  : the scheduler
interface ycc_stream_scheduler_if;
   logic [31:0] y_bitstream;
   logic        y_data_ready;
   logic [4:0]  y_orc;
   logic        y_eob;
   logic [31:0] cb_bitstream;
   logic        cb_data_ready;
   logic [4:0]  cb_orc;
   logic        cb_eob;
   logic [31:0] cr_bitstream;
   logic        cr_data_ready;
   logic [4:0]  cr_orc;
   logic        cr_eob;
   logic [31:0] out_bitstream;
   logic [4:0]  out_orc;
   logic        out_eob;
   logic [1:0]  out_channel;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] mcu_count;
   logic [2:0]  ovf_flags;
   logic        stall_err;

   modport master (
      output y_bitstream, y_data_ready, y_orc, y_eob,
      output cb_bitstream, cb_data_ready, cb_orc, cb_eob,
      output cr_bitstream, cr_data_ready, cr_orc, cr_eob,
      output out_ready,
      input  out_bitstream, out_orc, out_eob, out_channel, out_valid,
      input  mcu_count, ovf_flags, stall_err
   );

   modport slave (
      input  y_bitstream, y_data_ready, y_orc, y_eob,
      input  cb_bitstream, cb_data_ready, cb_orc, cb_eob,
      input  cr_bitstream, cr_data_ready, cr_orc, cr_eob,
      input  out_ready,
      output out_bitstream, out_orc, out_eob, out_channel, out_valid,
      output mcu_count, ovf_flags, stall_err
   );
endinterface

// File: rtl/ycc_stream_scheduler.sv
// rtl/ycc_stream_scheduler.sv - Round-robin Y/Cb/Cr block scheduler onto one 32-bit word stream
//
// Purpose: buffers each component's encoded words in its own show-ahead FIFO and
// drains one complete block per component in the order Y -> Cb -> Cr.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : ycc_stream_scheduler_if.slave (component inputs, output stream, status)
// Parameters:
//   FIFO_DEPTH : entries per component FIFO (power of 2, >= 2)
//   WD_CYCLES  : stall threshold for the watchdog
// Optional feature: define SCHED_WATCHDOG_EN to build the stall watchdog;
// otherwise stall_err is tied low.
module ycc_stream_scheduler #(
   parameter int FIFO_DEPTH = 16,
   parameter int WD_CYCLES  = 1024
) (
   input logic                 clk,
   input logic                 rst,
   ycc_stream_scheduler_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 38;
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {
      SERVE_Y  = 2'd0,
      SERVE_CB = 2'd1,
      SERVE_CR = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] mcu_q;

   // Per-channel push side; entry format {eob, orc, data}.
   logic [EW-1:0] push_entry [3];
   logic [2:0]    push_req;
   logic [EW-1:0] head       [3];
   logic [2:0]    empty_vec;
   logic [2:0]    ovf_vec;
   logic [2:0]    pop;

   always_comb begin
      push_entry[0] = {bus.y_eob,  bus.y_orc,  bus.y_bitstream};
      push_entry[1] = {bus.cb_eob, bus.cb_orc, bus.cb_bitstream};
      push_entry[2] = {bus.cr_eob, bus.cr_orc, bus.cr_bitstream};
      push_req      = {bus.cr_data_ready, bus.cb_data_ready, bus.y_data_ready};
   end

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_fifo
         logic [EW-1:0] mem [FIFO_DEPTH];
         logic [AW:0]   wr_ptr;
         logic [AW:0]   rd_ptr;
         logic          empty;
         logic          full;
         logic          accept;
         logic          ovf_q;

         assign empty  = (wr_ptr == rd_ptr);
         assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
         // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
         assign accept = push_req[g] && (!full || pop[g]);

         assign head[g]      = mem[rd_ptr[AW-1:0]];
         assign empty_vec[g] = empty;
         assign ovf_vec[g]   = ovf_q;

         always_ff @(posedge clk) begin
            if (accept) begin
               mem[wr_ptr[AW-1:0]] <= push_entry[g];
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               ovf_q  <= 1'b0;
            end else begin
               if (accept) begin
                  wr_ptr <= wr_ptr + PTR_ONE;
               end
               if (pop[g]) begin
                  rd_ptr <= rd_ptr + PTR_ONE;
               end
               if (push_req[g] && full && !pop[g]) begin
                  ovf_q <= 1'b1;
               end
            end
         end
      end
   endgenerate

   // Served-channel selection.
   logic          sel_empty;
   logic [EW-1:0] sel_head;
   logic [2:0]    served_oh;

   always_comb begin
      sel_empty = 1'b1;
      sel_head  = '0;
      served_oh = 3'b000;
      case (state)
         SERVE_Y: begin
            sel_empty = empty_vec[0];
            sel_head  = head[0];
            served_oh = 3'b001;
         end
         SERVE_CB: begin
            sel_empty = empty_vec[1];
            sel_head  = head[1];
            served_oh = 3'b010;
         end
         SERVE_CR: begin
            sel_empty = empty_vec[2];
            sel_head  = head[2];
            served_oh = 3'b100;
         end
         default: begin
            sel_empty = 1'b1;
            sel_head  = '0;
            served_oh = 3'b000;
         end
      endcase
   end

   logic out_valid_c;
   logic transfer;
   logic eob_transfer;

   assign out_valid_c  = !sel_empty;
   assign transfer     = out_valid_c && bus.out_ready;
   assign eob_transfer = transfer && sel_head[37];
   assign pop          = transfer ? served_oh : 3'b000;

   // Data fields are masked so an empty served FIFO shows all zeros, not stale memory.
   assign bus.out_valid     = out_valid_c;
   assign bus.out_bitstream = out_valid_c ? sel_head[31:0]  : 32'd0;
   assign bus.out_orc       = out_valid_c ? sel_head[36:32] : 5'd0;
   assign bus.out_eob       = out_valid_c ? sel_head[37]    : 1'b0;
   assign bus.out_channel   = state;
   assign bus.mcu_count     = mcu_q;
   assign bus.ovf_flags     = ovf_vec;

   // Round-robin block sequencer: moves on only once a block's last word has left.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SERVE_Y;
         mcu_q <= 16'd0;
      end else if (eob_transfer) begin
         case (state)
            SERVE_Y:  state <= SERVE_CB;
            SERVE_CB: state <= SERVE_CR;
            SERVE_CR: begin
               state <= SERVE_Y;
               mcu_q <= mcu_q + 16'd1;
            end
            default:  state <= SERVE_Y;
         endcase
      end
   end

`ifdef SCHED_WATCHDOG_EN
   localparam logic [15:0] WD_LIM = 16'(WD_CYCLES);

   logic [15:0] stall_cnt;
   logic        stall_q;
   logic        others_busy;

   // Stalled means the served FIFO is dry while some other component has data waiting.
   assign others_busy   = |(~empty_vec & ~served_oh);
   assign bus.stall_err = stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= 16'd0;
         stall_q   <= 1'b0;
      end else if (transfer) begin
         // Every state change is itself a transfer, so this covers both clear conditions.
         stall_cnt <= 16'd0;
      end else if (sel_empty && others_busy && (stall_cnt != WD_LIM)) begin
         stall_cnt <= stall_cnt + 16'd1;
         if (stall_cnt + 16'd1 == WD_LIM) begin
            stall_q <= 1'b1;
         end
      end
   end
`else
   assign bus.stall_err = 1'b0;
`endif

endmodule

// File: doc/ycc_stream_scheduler.md
Name: ycc_stream_scheduler

Overview:
Sequences the three per-component encoder bitstreams (Y, Cb, Cr) into one ordered 32-bit word stream for the output FIFO/packer. Each component has its own small show-ahead FIFO. A round-robin state machine drains one complete block per component, in the order Y → Cb → Cr, before moving to the next component. Block boundaries come from a per-word end-of-block tag.

Parameters:
- FIFO_DEPTH, 16, entries per component FIFO; must be a power of 2 and ≥ 2.
- WD_CYCLES, 1024, watchdog stall threshold in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- y_bitstream  in  32  Y encoded word.
- y_data_ready  in  1  Y word valid, one-cycle strobe.
- y_orc  in  5  Y valid-bit count for the word.
- y_eob  in  1  Y word is the last word of its block.
- cb_bitstream / cb_data_ready / cb_orc / cb_eob  in  32/1/5/1  Cb, same meaning as Y.
- cr_bitstream / cr_data_ready / cr_orc / cr_eob  in  32/1/5/1  Cr, same meaning as Y.
- out_bitstream  out  32  head word of the channel being served.
- out_orc  out  5  orc of the head word.
- out_eob  out  1  head word closes a block.
- out_channel  out  2  served channel: 0 = Y, 1 = Cb, 2 = Cr.
- out_valid  out  1  head word available.
- out_ready  in  1  downstream accepts the word.
- mcu_count  out  16  count of completed Y/Cb/Cr block triplets.
- ovf_flags  out  3  sticky overflow flags, {cr, cb, y}.
- stall_err  out  1  sticky watchdog flag (optional feature only).

Behaviour:
- Reset (rst = 0, asynchronous):
  - All FIFO pointers and counts go to 0.
  - State = SERVE_Y.
  - out_valid = 0; out_bitstream, out_orc, out_eob = 0; out_channel = 0.
  - mcu_count = 0; ovf_flags = 0; stall_err = 0.
  - Reset asserted mid-block discards all buffered words. Operation resumes at SERVE_Y.
- FIFO entry format: {eob, orc[4:0], data[31:0]}, 38 bits.
- Push: on a data_ready strobe, the word is written at the rising edge.
  - A word pushed in cycle N is visible at the FIFO head in cycle N+1.
- Full FIFO:
  - Push while full with no pop in the same cycle: word dropped, that channel's ovf_flags bit set. The bit stays set until reset.
  - Push while full with a pop in the same cycle: word accepted, count unchanged, no overflow.
- Empty FIFO: simultaneous push and pop on an empty FIFO cannot occur, since out_valid = 0 in that cycle.
- Output path is combinational from the head of the served FIFO:
  - out_valid = !empty(served channel).
  - out_channel = encoding of the current state.
  - Data fields come from the head entry; all data fields read 0 when out_valid = 0.
- Transfer: happens when out_valid && out_ready, and pops the served FIFO.
  - out_ready may be asserted while out_valid = 0 (no effect).
  - While out_valid = 1 and out_ready = 0, all outputs hold stable.
- State machine: SERVE_Y → SERVE_CB → SERVE_CR → SERVE_Y.
  - Advance only on a transfer with out_eob = 1; the new state takes effect the next cycle.
  - A transfer with out_eob = 0 keeps the current state.
  - Other FIFOs keep accepting pushes while not served.
  - No channel is skipped. An empty served FIFO simply stalls (out_valid = 0).
- mcu_count: increments by 1 on an eob transfer in SERVE_CR. Wraps 0xFFFF → 0x0000.
- FIFO pointers: log2(FIFO_DEPTH) bits plus one wrap bit. Full/empty are derived from the pointer compare.

Optional Feature:
- Macro: SCHED_WATCHDOG_EN.
- When defined:
  - A 16-bit stall counter increments each cycle that the served FIFO is empty while at least one other FIFO is non-empty.
  - The counter clears on any transfer or any state change.
  - When the counter reaches WD_CYCLES, stall_err is set. It is sticky until reset, and the counter saturates.
- When not defined: no counter logic is generated and stall_err is tied to 0.

Test Plan:
1. One block each: Y, Cb, Cr pushed with 3, 2, 1 words (eob on the last of each), out_ready = 1 → output order Y0 Y1 Y2 Cb0 Cb1 Cr0, out_channel 0,0,0,1,1,2, mcu_count = 1.
2. Cr block arrives first, Y block arrives 20 cycles later → out_valid = 0 until the first Y word is at the head; then Y, Cb, Cr drain in order, with Cr data intact.
3. Backpressure: out_ready = 0 for 10 cycles with valid Y head 0xDEADBEEF, orc 5'd17 → outputs stable for all 10 cycles; one pop occurs when out_ready = 1.
4. Overflow: 17 Y pushes with FIFO_DEPTH = 16 and no pops → ovf_flags = 3'b001; the 17th word is absent from the output; the flag persists afterwards.
5. Full FIFO with simultaneous push and pop → no overflow; count stays at 16; words emerge in order.
6. Reset asserted mid-Cb-block with 5 words buffered → all outputs 0 immediately; after release, state is SERVE_Y. With SCHED_WATCHDOG_EN and WD_CYCLES = 8: Y empty, Cb non-empty for 8 cycles → stall_err = 1.
